// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave of the byte stream and drives the memory write side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs a little-endian byte stream into
// 32-bit words, writes them from address 0 up, and holds the CPU until done.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_loader_if.slave     bus,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       asm_q;
    logic              byte_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              byte_fire;
    logic              count_ok;
    logic              word_last;
    logic [31:0]       asm_d;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        byte_fire = byte_ready_q & bus.byte_valid;
        count_ok  = (word_count != '0) && (word_count <= CNT_W'(DEPTH));
        word_last = ((word_cnt_q + CNT_W'(1)) == count_q);
        asm_d     = asm_q;
        case (byte_idx_q)
            2'd0:    asm_d[7:0]   = bus.byte_in;
            2'd1:    asm_d[15:8]  = bus.byte_in;
            2'd2:    asm_d[23:16] = bus.byte_in;
            default: asm_d[31:24] = bus.byte_in;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (count_ok) begin
                            state_q      <= LOAD;
                            count_q      <= word_count;
                            word_cnt_q   <= '0;
                            byte_idx_q   <= '0;
                            asm_q        <= '0;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                            cpu_hold_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (byte_fire) begin
                        if (byte_idx_q == 2'd3) begin
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= word_cnt_q[ADDR_W-1:0];
                            wr_data_q  <= asm_d;
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                            byte_idx_q <= '0;
                            asm_q      <= '0;
                            // Leave LOAD together with the final strobe so no extra byte is taken.
                            if (word_last) begin
                                state_q      <= DONE;
                                byte_ready_q <= 1'b0;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                cpu_hold_q   <= 1'b0;
                            end
                        end else begin
                            asm_q      <= asm_d;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent
// and compared by a monitor whenever the loader strobes wr_en.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .start      (start),
        .word_count (word_count),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          exp_addr = 0;
    wr_t         sb[$];
    int          wr_cycles[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (bus_if.wr_en === 1'b1) begin
            wr_cycles.push_back(cyc);
            wr_count++;
            if (sb.size() == 0) begin
                check("unexpected_wr_en", {63'd0, bus_if.wr_en}, 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {58'd0, bus_if.wr_addr}, {58'd0, e.addr});
                check("wr_data", {32'd0, bus_if.wr_data}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, {63'd0, bus_if.byte_ready}, 64'd0);
        check({tag, "_wr_en"},      {63'd0, bus_if.wr_en},      64'd0);
        check({tag, "_wr_addr"},    {58'd0, bus_if.wr_addr},    64'd0);
        check({tag, "_wr_data"},    {32'd0, bus_if.wr_data},    64'd0);
        check({tag, "_cpu_hold"},   {63'd0, cpu_hold},          64'd1);
        check({tag, "_busy"},       {63'd0, busy},              64'd0);
        check({tag, "_done"},       {63'd0, done},              64'd0);
        check({tag, "_err"},        {63'd0, err},               64'd0);
    endtask

    task automatic start_load(input int cnt);
        word_count = CNT_W'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        exp_addr   = 0;
    endtask

    task automatic illegal_start(input string tag, input int cnt, input logic exp_done);
        word_count = CNT_W'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        @(negedge clk);
        check({tag, "_err_pulse"}, {63'd0, err},  64'd1);
        check({tag, "_busy"},      {63'd0, busy}, 64'd0);
        check({tag, "_done"},      {63'd0, done}, {63'd0, exp_done});
        tick();
        @(negedge clk);
        check({tag, "_err_clear"}, {63'd0, err},  64'd0);
    endtask

    // gap=1 inserts two idle cycles with a junk byte after every transfer.
    task automatic send_word(input logic [31:0] data, input bit gap);
        wr_t e;
        logic [31:0] w;
        e.addr = ADDR_W'(exp_addr);
        e.data = data;
        sb.push_back(e);
        exp_addr++;
        w = data;
        for (int k = 0; k < 4; k++) begin
            bus_if.byte_valid = 1'b1;
            bus_if.byte_in    = w[8*k +: 8];
            tick();
            if (gap) begin
                bus_if.byte_valid = 1'b0;
                bus_if.byte_in    = 8'hEE;
                repeat (2) tick();
            end
        end
    endtask

    initial begin
        logic [31:0] words [3];
        words[0] = 32'h00002083;
        words[1] = 32'h00402103;
        words[2] = 32'h00802183;

        rst_n             = 1'b0;
        start             = 1'b0;
        word_count        = '0;
        bus_if.byte_in    = 8'h00;
        bus_if.byte_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Illegal counts from IDLE
        illegal_start("idle_cnt0", 0, 1'b0);
        illegal_start("idle_cnt65", 65, 1'b0);
        check("idle_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        check("idle_no_wr", wr_count, 0);

        // Single word
        start_load(1);
        @(negedge clk);
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_byte_ready", {63'd0, bus_if.byte_ready}, 64'd1);
        check("t1_done_low", {63'd0, done}, 64'd0);
        send_word(32'h00002083, 1'b0);
        bus_if.byte_valid = 1'b0;
        @(negedge clk);
        check("t1_wr_en", {63'd0, bus_if.wr_en}, 64'd1);
        check("t1_done", {63'd0, done}, 64'd1);
        check("t1_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        check("t1_busy_low", {63'd0, busy}, 64'd0);
        check("t1_byte_ready_low", {63'd0, bus_if.byte_ready}, 64'd0);
        tick();
        @(negedge clk);
        check("t1_wr_en_one_cycle", {63'd0, bus_if.wr_en}, 64'd0);
        check("t1_wr_data_hold", {32'd0, bus_if.wr_data}, 64'h00002083);
        check("t1_done_held", {63'd0, done}, 64'd1);

        // Three words, no gaps, restarted from DONE
        wr_cycles.delete();
        start_load(3);
        @(negedge clk);
        check("t2_done_clear", {63'd0, done}, 64'd0);
        check("t2_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        for (int i = 0; i < 3; i++) send_word(words[i], 1'b0);
        bus_if.byte_valid = 1'b1;
        bus_if.byte_in    = 8'hAA;
        repeat (4) tick();
        bus_if.byte_valid = 1'b0;
        @(negedge clk);
        check("t2_writes", wr_cycles.size(), 3);
        if (wr_cycles.size() == 3) begin
            check("t2_gap01", wr_cycles[1] - wr_cycles[0], 4);
            check("t2_gap12", wr_cycles[2] - wr_cycles[1], 4);
        end
        check("t2_done", {63'd0, done}, 64'd1);
        check("t2_byte_ready_low", {63'd0, bus_if.byte_ready}, 64'd0);

        // Illegal count while DONE, then the same words with valid gaps
        illegal_start("done_cnt0", 0, 1'b1);
        wr_count = 0;
        start_load(3);
        for (int i = 0; i < 3; i++) send_word(words[i], 1'b1);
        tick();
        @(negedge clk);
        check("t3_writes", wr_count, 3);
        check("t3_done", {63'd0, done}, 64'd1);

        // Full-depth load
        wr_count = 0;
        start_load(DEPTH);
        for (int i = 0; i < DEPTH; i++) send_word($urandom, 1'b0);
        bus_if.byte_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("t5_writes", wr_count, DEPTH);
        check("t5_sb_empty", sb.size(), 0);
        check("t5_last_addr", {58'd0, bus_if.wr_addr}, 64'd63);
        check("t5_done", {63'd0, done}, 64'd1);

        // Reset after two bytes of word 5
        start_load(8);
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
        bus_if.byte_valid = 1'b1;
        bus_if.byte_in    = 8'h11;
        tick();
        bus_if.byte_in    = 8'h22;
        tick();
        bus_if.byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_sb_empty", sb.size(), 0);
        start_load(1);
        send_word(32'hCAFE_F00D, 1'b0);
        bus_if.byte_valid = 1'b0;
        @(negedge clk);
        check("t6_wr_en", {63'd0, bus_if.wr_en}, 64'd1);
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the 64-entry x 32-bit instruction memory. It accepts a byte stream over a valid/ready handshake and assembles each group of four bytes, little-endian, into one instruction word. It writes each word to sequential instruction-memory addresses starting at 0. It holds the CPU stalled until the requested number of words has been written, then releases it.

Parameters:
ADDR_W, 6, instruction-memory word-address width
DEPTH, 64, number of instruction-memory words; maximum load length
CNT_W, 7, width of word_count (must hold DEPTH)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE and DONE
word_count  input  CNT_W  number of words to load, sampled on the cycle start is accepted; legal range 1..DEPTH
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  word address for the write
wr_data  output  32  assembled instruction word
cpu_hold  output  1  stall / reset request to the CPU
busy  output  1  load in progress
done  output  1  load completed; held
err  output  1  one-cycle pulse on an illegal word_count

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, busy=0, done=0, err=0. Byte index, word counter and assembly register all clear.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 with word_count in 1..DEPTH -> LOAD. Latch word_count; next word address=0; byte index=0.
  - start=1 with word_count=0 or >DEPTH -> err=1 for exactly the next cycle; stay in IDLE.
- LOAD:
  - busy=1, byte_ready=1, cpu_hold=1.
  - A byte transfers when byte_valid & byte_ready.
  - Byte k (k=0..3) of a word goes to assembly bits [8k+7:8k], so the first byte received is the LSB.
  - byte_valid gaps are allowed; the byte index advances only on a transfer.
- Word write:
  - On the transfer of byte 3, wr_data and wr_addr are registered.
  - wr_en=1 for exactly the following cycle, with wr_addr = current word address.
  - The word address then increments and the byte index returns to 0.
  - byte_ready stays 1 during the wr_en cycle, so back-to-back words run with no bubble.
- Completion: when the written-word count reaches the latched count, the FSM moves to DONE in the cycle wr_en is asserted for the last word.
  - The last write always completes.
  - No byte is accepted after the last byte 3; byte_ready=0 from the cycle following that transfer.
- DONE:
  - done=1, cpu_hold=0, busy=0, byte_ready=0.
  - start with a legal count starts a new load: done clears and cpu_hold rises the next cycle.
  - start with an illegal count pulses err and stays in DONE.
- start during LOAD is ignored.
- wr_addr never exceeds latched count-1 and never wraps; a count of DEPTH ends at address DEPTH-1.
- Reset mid-load:
  - Return to IDLE immediately and discard any partial word.
  - A wr_en in flight is dropped.
  - Words already written remain in memory; the loader does not clear memory.
- wr_data/wr_addr hold their last value when wr_en=0.

Test Plan:
- Single word: start, word_count=1; bytes 83,20,00,00 (lw x1,0(x0)) -> one wr_en cycle after the 4th byte with wr_addr=0, wr_data=0x00002083; done=1 and cpu_hold=0 from that cycle.
- Three words, byte_valid continuously high: bytes of 0x00002083, 0x00402103, 0x00802183 -> wr_en at addrs 0,1,2, exactly 4 cycles apart; done after the third write; byte_ready=0 afterwards.
- Backpressure/gaps: byte_valid toggles 1,0,0,1,... -> the same words and addresses as the gap-free run; the byte index does not advance on idle cycles.
- Illegal counts: word_count=0, then 65 -> err pulses one cycle each; state stays IDLE; no wr_en.
- Full load: word_count=64 -> 64 writes at addrs 0..63 in order; last wr_data matches the last 4 bytes sent; no address 0 rewrite.
- Reset mid-load: rst_n low after 2 bytes of word 5 -> all outputs at reset values; a new start with count=1 writes addr 0 with the fresh bytes only.
